// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, PMOD bus bit map and lock FSM encoding
// used by both the TinyVGA pattern generator and the capture block.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = 525;

  // PMOD bus: {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}
  localparam int PMOD_HSYNC = 7;
  localparam int PMOD_B0    = 6;
  localparam int PMOD_G0    = 5;
  localparam int PMOD_R0    = 4;
  localparam int PMOD_VSYNC = 3;
  localparam int PMOD_B1    = 2;
  localparam int PMOD_G1    = 1;
  localparam int PMOD_R1    = 0;

  typedef logic [1:0] lock_state_t;
  localparam lock_state_t ST_SEARCH  = 2'd0;
  localparam lock_state_t ST_MEASURE = 2'd1;
  localparam lock_state_t ST_LOCKED  = 2'd2;

endpackage

// File: rtl/vga_sync_edge.sv
// PMOD input capture: sync polarity normalisation, two register stages and
// sync assertion edge detection. Syncs are stored as 1 = asserted.
module vga_sync_edge
  import vga_timing_pkg::*;
#(
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] vga_in,
  output logic       h_edge,
  output logic       v_edge,
  output logic [5:0] rgb_p1
);

  logic       hs_in, vs_in;
  logic [5:0] rgb_in;
  logic       hs_p0, vs_p0, hs_p1, vs_p1;
  logic [5:0] rgb_p0;

  assign hs_in  = vga_in[PMOD_HSYNC] ^ SYNC_ACTIVE_LOW;
  assign vs_in  = vga_in[PMOD_VSYNC] ^ SYNC_ACTIVE_LOW;
  assign rgb_in = {vga_in[PMOD_R1], vga_in[PMOD_R0], vga_in[PMOD_G1],
                   vga_in[PMOD_G0], vga_in[PMOD_B1], vga_in[PMOD_B0]};

  // p0 / p1: raw bus capture, cleared to deasserted sync and black
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_p0  <= 1'b0;
      vs_p0  <= 1'b0;
      rgb_p0 <= '0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      rgb_p1 <= '0;
    end else begin
      hs_p0  <= hs_in;
      vs_p0  <= vs_in;
      rgb_p0 <= rgb_in;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      rgb_p1 <= rgb_p0;
    end
  end

  assign h_edge = hs_p0 & ~hs_p1;
  assign v_edge = vs_p0 & ~vs_p1;

endmodule

// File: rtl/vga_capture.sv
// TinyVGA PMOD receiver: recovers pixel coordinates from sync edges, verifies
// frame timing and emits a locked per-pixel valid stream.
module vga_capture #(
  parameter int H_ACTIVE        = vga_timing_pkg::H_ACTIVE,
  parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
  parameter int H_BACK          = vga_timing_pkg::H_BACK,
  parameter int H_TOTAL         = vga_timing_pkg::H_TOTAL,
  parameter int V_ACTIVE        = vga_timing_pkg::V_ACTIVE,
  parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
  parameter int V_BACK          = vga_timing_pkg::V_BACK,
  parameter int V_TOTAL         = vga_timing_pkg::V_TOTAL,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  vga_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_error,
  output logic [15:0] frame_count
);
  import vga_timing_pkg::*;

  localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  logic        h_edge, v_edge;
  logic [5:0]  rgb_p1;
  logic [9:0]  h_cnt_p1, v_cnt_p1;
  lock_state_t state, state_nxt;
  logic        h_exempt, h_bad, v_bad;
  logic        err_nxt, fc_inc_nxt, err_p1, fc_inc_p1;
  logic        active_p1, valid_p1;

  vga_sync_edge #(
    .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .vga_in (vga_in),
    .h_edge (h_edge),
    .v_edge (v_edge),
    .rgb_p1 (rgb_p1)
  );

  // Checks compare the count reached by the previous line/frame at the new edge
  always_comb begin
    h_bad      = h_edge && (h_cnt_p1 != H_LAST) && !(h_exempt && state == ST_MEASURE);
    v_bad      = v_edge && (v_cnt_p1 != V_LAST);
    state_nxt  = state;
    err_nxt    = 1'b0;
    fc_inc_nxt = 1'b0;
    case (state)
      ST_SEARCH:  if (v_edge) state_nxt = ST_MEASURE;
      ST_MEASURE: begin
        if (h_bad || v_bad) state_nxt = ST_SEARCH;
        else if (v_edge)    state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (h_bad || v_bad) begin
          state_nxt = ST_SEARCH;
          err_nxt   = 1'b1;
        end else if (v_edge) begin
          fc_inc_nxt = 1'b1;
        end
      end
      default:    state_nxt = ST_SEARCH;
    endcase
  end

  // p1: counters and FSM, aligned with the word in the second input register
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_p1  <= '0;
      v_cnt_p1  <= '0;
      state     <= ST_SEARCH;
      h_exempt  <= 1'b0;
      err_p1    <= 1'b0;
      fc_inc_p1 <= 1'b0;
    end else begin
      if (h_edge) begin
        h_cnt_p1 <= '0;
        v_cnt_p1 <= v_edge ? 10'd0 : sat_inc(v_cnt_p1);
      end else begin
        h_cnt_p1 <= sat_inc(h_cnt_p1);
      end
      state     <= state_nxt;
      err_p1    <= err_nxt;
      fc_inc_p1 <= fc_inc_nxt;
      if (state == ST_SEARCH && v_edge) h_exempt <= 1'b1;
      else if (h_edge)                  h_exempt <= 1'b0;
    end
  end

  assign active_p1 = (h_cnt_p1 >= H_START) && (h_cnt_p1 < H_END) &&
                     (v_cnt_p1 >= V_START) && (v_cnt_p1 < V_END);
  assign valid_p1  = active_p1 && (state == ST_LOCKED);

  // p2: registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      rgb         <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_error  <= 1'b0;
      frame_count <= '0;
    end else begin
      pix_valid   <= valid_p1;
      pix_x       <= valid_p1 ? h_cnt_p1 - H_START : 10'd0;
      pix_y       <= valid_p1 ? v_cnt_p1 - V_START : 10'd0;
      rgb         <= valid_p1 ? rgb_p1 : 6'd0;
      frame_start <= valid_p1 && (h_cnt_p1 == H_START) && (v_cnt_p1 == V_START);
      locked      <= (state == ST_LOCKED);
      sync_error  <= err_p1;
      if (fc_inc_p1) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 16x12 raster (8x6 visible);
// a second instance sees the same video with active-high syncs.
module tb_vga_capture;

  localparam int HA = 8, HS = 2, HB = 2, HT = 16;
  localparam int VA = 6, VS = 2, VB = 2, VT = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  vga_a = 8'h00, vga_b = 8'h00;
  logic        pix_valid_a, frame_start_a, locked_a, sync_error_a;
  logic        pix_valid_b, frame_start_b, locked_b, sync_error_b;
  logic [9:0]  pix_x_a, pix_y_a, pix_x_b, pix_y_b;
  logic [5:0]  rgb_a, rgb_b;
  logic [15:0] frame_count_a, frame_count_b;
  logic [45:0] out_a, out_b;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int hc = 0, vc = 0, cur_len = HT, cur_lines = VT;
  bit short_line_req = 1'b0, short_frame_req = 1'b0, gen_pause = 1'b1;
  int pv_a, pv_b, fs_a, fs_b, se_a, se_b;

  always #5 clk = ~clk;

  vga_capture #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT), .SYNC_ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .reset(reset), .vga_in(vga_a), .pix_valid(pix_valid_a),
    .pix_x(pix_x_a), .pix_y(pix_y_a), .rgb(rgb_a), .frame_start(frame_start_a),
    .locked(locked_a), .sync_error(sync_error_a), .frame_count(frame_count_a)
  );

  vga_capture #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT), .SYNC_ACTIVE_LOW(0)
  ) dut_b (
    .clk(clk), .reset(reset), .vga_in(vga_b), .pix_valid(pix_valid_b),
    .pix_x(pix_x_b), .pix_y(pix_y_b), .rgb(rgb_b), .frame_start(frame_start_b),
    .locked(locked_b), .sync_error(sync_error_b), .frame_count(frame_count_b)
  );

  assign out_a = {pix_valid_a, pix_x_a, pix_y_a, rgb_a, frame_start_a, locked_a, sync_error_a, frame_count_a};
  assign out_b = {pix_valid_b, pix_x_b, pix_y_b, rgb_b, frame_start_b, locked_b, sync_error_b, frame_count_b};

  function automatic logic [5:0] pat(input int x, input int y);
    return 6'((x * 5 + y * 11 + 42) & 63);
  endfunction

  // c = {R1,R0,G1,G0,B1,B0}; bus = {hsync,B0,G0,R0,vsync,B1,G1,R1}
  function automatic logic [7:0] pack_bus(input bit hs, input bit vs, input logic [5:0] c, input bit act_low);
    logic hl, vl;
    hl = hs ^ act_low;
    vl = vs ^ act_low;
    return {hl, c[0], c[2], c[4], vl, c[1], c[3], c[5]};
  endfunction

  task automatic clr();
    pv_a = 0; pv_b = 0; fs_a = 0; fs_b = 0; se_a = 0; se_b = 0;
  endtask

  task automatic tick();
    bit hs, vs;
    int x, y;
    logic [5:0] c;
    if (gen_pause) begin
      vga_a = pack_bus(1'b0, 1'b0, 6'd0, 1'b1);
      vga_b = pack_bus(1'b0, 1'b0, 6'd0, 1'b0);
    end else begin
      if (hc == 0 && vc == 0) begin
        cur_lines = short_frame_req ? VT - 1 : VT;
        short_frame_req = 1'b0;
      end
      if (hc == 0) begin
        cur_len = (short_line_req && vc == 3) ? HT - 1 : HT;
        if (vc == 3) short_line_req = 1'b0;
      end
      hs = (hc < HS);
      vs = (vc < VS);
      x = hc - (HS + HB);
      y = vc - (VS + VB);
      c = (x >= 0 && x < HA && y >= 0 && y < VA) ? pat(x, y) : 6'd0;
      vga_a = pack_bus(hs, vs, c, 1'b1);
      vga_b = pack_bus(hs, vs, c, 1'b0);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (pix_valid_a)   pv_a++;
    if (pix_valid_b)   pv_b++;
    if (frame_start_a) fs_a++;
    if (frame_start_b) fs_b++;
    if (sync_error_a)  se_a++;
    if (sync_error_b)  se_b++;
    if (!gen_pause) begin
      hc++;
      if (hc == cur_len) begin
        hc = 0;
        vc++;
        if (vc == cur_lines) vc = 0;
      end
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    check({tag, "/alow"}, a, exp);
    check({tag, "/ahigh"}, b, exp);
  endtask

  initial begin
    clr();
    repeat (3) tick();
    chk2("reset_outputs", 64'(out_a), 64'(out_b), 64'd0);
    reset = 1'b0;
    gen_pause = 1'b0;
    cyc = 0;
    clr();

    // first vsync edge -> MEASURE, second (word 192) -> LOCKED, visible at cycle 195
    run_to(193);
    chk2("measure_pv_count", 64'(pv_a), 64'(pv_b), 64'd0);
    run_to(194);
    chk2("locked_before", 64'(locked_a), 64'(locked_b), 64'd0);
    clr();
    run_to(195);
    chk2("locked_after_2nd_vsync", 64'(locked_a), 64'(locked_b), 64'd1);

    run_to(262);
    chk2("pv_before_origin", 64'(pix_valid_a), 64'(pix_valid_b), 64'd0);
    run_to(263);
    chk2("pixel_0_0", 64'(out_a), 64'(out_b), 64'({1'b1, 10'd0, 10'd0, 6'h2A, 1'b1, 1'b1, 1'b0, 16'd0}));
    run_to(350);
    chk2("pixel_7_5", 64'(out_a), 64'(out_b), 64'({1'b1, 10'd7, 10'd5, 6'h04, 1'b0, 1'b1, 1'b0, 16'd0}));
    run_to(351);
    chk2("pv_rgb_after_line", 64'({pix_valid_a, rgb_a}), 64'({pix_valid_b, rgb_b}), 64'd0);
    run_to(386);
    chk2("frame_pv_count", 64'(pv_a), 64'(pv_b), 64'd48);
    chk2("frame_start_count", 64'(fs_a), 64'(fs_b), 64'd1);
    chk2("frame_count_pre", 64'(frame_count_a), 64'(frame_count_b), 64'd0);
    run_to(387);
    chk2("frame_count_1", 64'(frame_count_a), 64'(frame_count_b), 64'd1);

    // 15-clock line at vc=3 of the next frame; bad h_edge is word 447
    short_line_req = 1'b1;
    run_to(449);
    chk2("pre_err_lock_se", 64'({locked_a, sync_error_a}), 64'({locked_b, sync_error_b}), 64'b10);
    run_to(450);
    chk2("short_line_err", 64'({pix_valid_a, locked_a, sync_error_a}),
         64'({pix_valid_b, locked_b, sync_error_b}), 64'b001);
    clr();
    run_to(451);
    chk2("se_one_cycle", 64'(sync_error_a), 64'(sync_error_b), 64'd0);
    run_to(769);
    chk2("unlocked_pv_count", 64'(pv_a), 64'(pv_b), 64'd0);
    chk2("no_second_err", 64'(se_a), 64'(se_b), 64'd0);
    chk2("relock_before", 64'(locked_a), 64'(locked_b), 64'd0);
    clr();
    run_to(770);
    chk2("relock", 64'(locked_a), 64'(locked_b), 64'd1);
    run_to(961);
    chk2("relock_pv_count", 64'(pv_a), 64'(pv_b), 64'd48);
    chk2("relock_fs_count", 64'(fs_a), 64'(fs_b), 64'd1);
    run_to(962);
    chk2("frame_count_2", 64'(frame_count_a), 64'(frame_count_b), 64'd2);

    // mid-line reset while locked, then an 11-line frame during MEASURE
    run_to(1000);
    chk2("locked_pre_reset", 64'(locked_a), 64'(locked_b), 64'd1);
    reset = 1'b1;
    short_frame_req = 1'b1;
    tick();
    chk2("mid_line_reset", 64'(out_a), 64'(out_b), 64'd0);
    reset = 1'b0;
    clr();
    run_to(1713);
    chk2("short_frame_no_err", 64'(se_a), 64'(se_b), 64'd0);
    chk2("short_frame_no_pv", 64'(pv_a), 64'(pv_b), 64'd0);
    chk2("short_frame_unlocked", 64'(locked_a), 64'(locked_b), 64'd0);
    run_to(1714);
    chk2("relock_after_reset", 64'({locked_a, frame_count_a}), 64'({locked_b, frame_count_b}),
         64'({1'b1, 16'd0}));

    // sync lost: counters saturate with no error until the next edge
    run_to(1720);
    gen_pause = 1'b1;
    clr();
    run_to(2920);
    chk2("sync_lost_no_err", 64'(se_a), 64'(se_b), 64'd0);
    chk2("sync_lost_no_pv", 64'(pv_a), 64'(pv_b), 64'd0);
    chk2("sync_lost_locked", 64'(locked_a), 64'(locked_b), 64'd1);
    gen_pause = 1'b0;
    clr();
    run_to(2940);
    chk2("sync_return_err", 64'(se_a), 64'(se_b), 64'd1);
    chk2("sync_return_unlocked", 64'(locked_a), 64'(locked_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
